// File: rtl/alpharetz_spi_peripheral.sv
// SPI target endpoint: oversamples the SPI pins on sys_clk, shifts LSB-first,
// hands received words out via rx_valid/rx_ack and takes tx words via tx_load.
module alpharetz_spi_peripheral #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter bit CPOL           = 1'b0,
    parameter bit CPHA           = 1'b0,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      sys_clk,
    input  logic                      sync_rst,
    input  logic                      sys_clk_en,
    input  logic                      p_clk,
    input  logic                      p_sel_n,
    input  logic                      copi,
    output logic                      cipo,
    output logic                      cipo_oe,
    input  logic [SPI_DATA_WIDTH-1:0] tx_data,
    input  logic                      tx_load,
    output logic                      tx_ready,
    output logic [SPI_DATA_WIDTH-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ack,
    output logic                      rx_overrun,
    output logic                      busy
);

    localparam int CW = (SPI_DATA_WIDTH > 2) ? $clog2(SPI_DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(SPI_DATA_WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    // [0] first sync flop, [SYNC_STAGES-1] synchronized value, [SYNC_STAGES] history
    logic [SYNC_STAGES:0] clk_sr, sel_sr, copi_sr;

    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            clk_sr  <= {(SYNC_STAGES+1){CPOL}};
            sel_sr  <= '1;
            copi_sr <= '0;
        end else if (sys_clk_en) begin
            clk_sr  <= {clk_sr[SYNC_STAGES-1:0], p_clk};
            sel_sr  <= {sel_sr[SYNC_STAGES-1:0], p_sel_n};
            copi_sr <= {copi_sr[SYNC_STAGES-1:0], copi};
        end
    end

    logic clk_s, clk_h, sel_s, sel_h, copi_d;
    logic lead_edge, trail_edge, sel_fall, sel_rise, sample_edge, drive_edge;

    assign clk_s  = clk_sr[SYNC_STAGES-1];
    assign clk_h  = clk_sr[SYNC_STAGES];
    assign sel_s  = sel_sr[SYNC_STAGES-1];
    assign sel_h  = sel_sr[SYNC_STAGES];
    // copi settles half a p_clk period before the sample edge, so the value
    // from the cycle just before the edge was seen is the safest to take.
    assign copi_d = copi_sr[SYNC_STAGES];

    assign lead_edge   = (clk_h == CPOL) && (clk_s != CPOL);
    assign trail_edge  = (clk_h != CPOL) && (clk_s == CPOL);
    assign sel_fall    = sel_h && !sel_s;
    assign sel_rise    = !sel_h && sel_s;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;

    state_t state, state_nxt;

    always_ff @(posedge sys_clk) begin
        if (sync_rst)
            state <= IDLE;
        else if (sys_clk_en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_fall) state_nxt = SHIFT;
            SHIFT:   if (sel_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic do_enter, do_abort, do_sample, do_drive;

    always_comb begin
        do_enter  = 1'b0;
        do_abort  = 1'b0;
        do_sample = 1'b0;
        do_drive  = 1'b0;
        case (state)
            IDLE: do_enter = sel_fall;
            SHIFT: begin
                if (sel_rise) begin
                    do_abort = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_drive  = drive_edge;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state == SHIFT);
    assign tx_ready = sel_s;

    logic [SPI_DATA_WIDTH-1:0] tx_buf, shreg;
    logic [CW-1:0]             bit_cnt;
    logic                      done_q;

    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            tx_buf     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            done_q     <= 1'b0;
            cipo       <= 1'b0;
            cipo_oe    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (sys_clk_en) begin
            done_q <= do_sample && (bit_cnt == LAST);

            if (tx_load && tx_ready)
                tx_buf <= tx_data;

            if (do_enter) begin
                shreg   <= tx_buf;
                tx_buf  <= '0;
                cipo_oe <= 1'b1;
                bit_cnt <= '0;
                if (!CPHA)
                    cipo <= tx_buf[0];
            end

            if (do_abort) begin
                bit_cnt <= '0;
                cipo_oe <= 1'b0;
                cipo    <= 1'b0;
            end

            if (do_drive)
                cipo <= shreg[0];

            if (do_sample) begin
                shreg   <= {copi_d, shreg[SPI_DATA_WIDTH-1:1]};
                bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
            end

            // Word complete: publish it and queue the next tx word (zero if not reloaded).
            if (done_q) begin
                rx_data <= shreg;
                shreg   <= tx_buf;
                tx_buf  <= '0;
            end

            if (done_q)
                rx_valid <= 1'b1;
            else if (rx_ack)
                rx_valid <= 1'b0;

            if (done_q && rx_valid && !rx_ack)
                rx_overrun <= 1'b1;
        end
    end

endmodule
